// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with an internal tick prescaler and active-low
// 7-segment decode per digit. Supports start/pause, one-shot or auto-reload, and expiry status.
module bcd_countdown_timer #(
  parameter int                        NUM_DIGITS = 2,
  parameter int                        TICK_DIV   = 100000000,
  parameter logic [4*NUM_DIGITS-1:0]   RESET_VAL  = 'h30
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [4*NUM_DIGITS-1:0]      load_val,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         auto_reload,
  output logic [4*NUM_DIGITS-1:0]      digits,
  output logic [8*NUM_DIGITS-1:0]      seg,
  output logic                         running,
  output logic                         done,
  output logic                         expire
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   reload_q, reload_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            expire_q, expire_d;
  logic            tick;
  logic [CW-1:0]   start_val;

  function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple borrow from digit 0 upward; a digit at 0 becomes 9 and passes the borrow on.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'd0:    s = 8'b00000011;
      4'd1:    s = 8'b10011111;
      4'd2:    s = 8'b00100101;
      4'd3:    s = 8'b00001101;
      4'd4:    s = 8'b10011001;
      4'd5:    s = 8'b01001001;
      4'd6:    s = 8'b01000001;
      4'd7:    s = 8'b00011111;
      4'd8:    s = 8'b00000001;
      4'd9:    s = 8'b00001001;
      default: s = 8'b01110001;
    endcase
    return s;
  endfunction

  assign tick      = (state_q == RUN) && (presc_q == PRE_MAX);
  // Restarting from DONE counts from the last loaded value, not the held zero.
  assign start_val = (state_q == DONE) ? reload_q : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= RESET_VAL;
      reload_q <= RESET_VAL;
      presc_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    expire_d = 1'b0;
    if (load) begin
      count_d  = clamp_bcd(load_val);
      reload_d = clamp_bcd(load_val);
      presc_d  = '0;
      state_d  = IDLE;
    end else if (start && (state_q != RUN)) begin
      count_d = start_val;
      if (state_q == DONE) presc_d = '0;
      if (start_val == '0) begin
        state_d  = DONE;
        expire_d = 1'b1;
      end else begin
        state_d  = RUN;
      end
    end else if (pause && !start && (state_q == RUN)) begin
      state_d = PAUSE;
    end else if (state_q == RUN) begin
      if (tick) begin
        presc_d = '0;
        // A zero count while running only follows an auto-reload expiry.
        if (count_q == '0) begin
          count_d = reload_q;
        end else if (count_q == CW'(1)) begin
          count_d  = '0;
          expire_d = 1'b1;
          if (!auto_reload) state_d = DONE;
        end else begin
          count_d = bcd_dec(count_q);
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    seg = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg[8*i +: 8] = seg_code(count_q[4*i +: 4]);
    end
  end

  assign digits  = count_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign expire  = expire_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: a 2-digit and a 3-digit instance checked against an
// integer reference model every cycle, plus a vector table and directed corner sequences.
module tb_bcd_countdown_timer;

  localparam int DIV = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  localparam logic [7:0] SEGS [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
                                      8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
                                      8'b00000001, 8'b00001001};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        ld2 = 1'b0, st2 = 1'b0, ps2 = 1'b0, ar2 = 1'b0;
  logic [7:0]  lv2 = '0;
  logic [7:0]  dg2;
  logic [15:0] sg2;
  logic        run2, dn2, ex2;
  logic        ld3 = 1'b0, st3 = 1'b0, ps3 = 1'b0, ar3 = 1'b0;
  logic [11:0] lv3 = '0;
  logic [11:0] dg3;
  logic [23:0] sg3;
  logic        run3, dn3, ex3;

  bcd_countdown_timer #(.NUM_DIGITS(2), .TICK_DIV(DIV), .RESET_VAL(8'h30)) u2 (
    .clk(clk), .rst(rst), .load(ld2), .load_val(lv2), .start(st2), .pause(ps2),
    .auto_reload(ar2), .digits(dg2), .seg(sg2), .running(run2), .done(dn2), .expire(ex2));

  bcd_countdown_timer #(.NUM_DIGITS(3), .TICK_DIV(DIV), .RESET_VAL(12'h030)) u3 (
    .clk(clk), .rst(rst), .load(ld3), .load_val(lv3), .start(st3), .pause(ps3),
    .auto_reload(ar3), .digits(dg3), .seg(sg3), .running(run3), .done(dn3), .expire(ex3));

  int total = 0;
  int bad   = 0;

  // Reference model: count as a plain decimal integer.
  int m_cnt [2];
  int m_rel [2];
  int m_st  [2];
  int m_pre [2];
  bit m_exp [2];

  typedef struct {
    bit         ld;
    logic [7:0] lv;
    bit         st;
    bit         ps;
    bit         ar;
    logic [7:0] dig;
    bit         run;
    bit         dn;
    bit         ex;
  } vec_t;

  vec_t tbl [36];

  function automatic vec_t mk(bit ld, logic [7:0] lv, bit st, bit ps, bit ar,
                              logic [7:0] dig, bit run, bit dn, bit ex);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.ps = ps; v.ar = ar;
    v.dig = dig; v.run = run; v.dn = dn; v.ex = ex;
    return v;
  endfunction

  function automatic int bcd_value(logic [11:0] v, int n);
    int r = 0;
    int w = 1;
    for (int i = 0; i < n; i++) begin
      int d;
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [11:0] to_bcd(int x);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] seg_exp(int x, int n);
    logic [23:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r[8*i +: 8] = SEGS[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 30; m_rel[k] = 30; m_st[k] = S_IDLE; m_pre[k] = 0; m_exp[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit a_ld, input int a_lv, input bit a_st,
                            input bit a_ps, input bit a_ar);
    m_exp[k] = 1'b0;
    if (a_ld) begin
      m_cnt[k] = a_lv; m_rel[k] = a_lv; m_pre[k] = 0; m_st[k] = S_IDLE;
    end else if (a_st && m_st[k] != S_RUN) begin
      if (m_st[k] == S_DONE) begin
        m_cnt[k] = m_rel[k]; m_pre[k] = 0;
      end
      if (m_cnt[k] == 0) begin
        m_st[k] = S_DONE; m_exp[k] = 1'b1;
      end else begin
        m_st[k] = S_RUN;
      end
    end else if (a_ps && !a_st && m_st[k] == S_RUN) begin
      m_st[k] = S_PAUSE;
    end else if (m_st[k] == S_RUN) begin
      if (m_pre[k] == DIV - 1) begin
        m_pre[k] = 0;
        if (m_cnt[k] > 1) begin
          m_cnt[k] = m_cnt[k] - 1;
        end else if (m_cnt[k] == 1) begin
          m_cnt[k] = 0; m_exp[k] = 1'b1;
          if (!a_ar) m_st[k] = S_DONE;
        end else begin
          m_cnt[k] = m_rel[k];
        end
      end else begin
        m_pre[k] = m_pre[k] + 1;
      end
    end
  endtask

  task automatic check_model();
    chk("model_dig2",  32'(dg2),  32'(to_bcd(m_cnt[0])));
    chk("model_seg2",  32'(sg2),  32'(seg_exp(m_cnt[0], 2)));
    chk("model_run2",  32'(run2), 32'(m_st[0] == S_RUN));
    chk("model_done2", 32'(dn2),  32'(m_st[0] == S_DONE));
    chk("model_exp2",  32'(ex2),  32'(m_exp[0]));
    chk("model_dig3",  32'(dg3),  32'(to_bcd(m_cnt[1])));
    chk("model_seg3",  32'(sg3),  32'(seg_exp(m_cnt[1], 3)));
    chk("model_run3",  32'(run3), 32'(m_st[1] == S_RUN));
    chk("model_done3", 32'(dn3),  32'(m_st[1] == S_DONE));
    chk("model_exp3",  32'(ex3),  32'(m_exp[1]));
  endtask

  task automatic cyc();
    if (rst) begin
      model_reset();
    end else begin
      model_step(0, ld2, bcd_value({4'b0, lv2}, 2), st2, ps2, ar2);
      model_step(1, ld3, bcd_value(lv3, 3), st3, ps3, ar3);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ld2 = 1'b0; st2 = 1'b0; ps2 = 1'b0;
    ld3 = 1'b0; st3 = 1'b0; ps3 = 1'b0;
    check_model();
  endtask

  initial begin
    int          ne;
    bit          run_all;
    logic [11:0] tmp;

    tbl[0]  = mk(1, 8'h03, 0, 0, 0, 8'h03, 0, 0, 0);
    tbl[1]  = mk(0, 8'h00, 1, 0, 0, 8'h03, 1, 0, 0);
    tbl[2]  = mk(0, 8'h00, 0, 0, 0, 8'h03, 1, 0, 0);
    tbl[3]  = mk(0, 8'h00, 0, 0, 0, 8'h03, 1, 0, 0);
    tbl[4]  = mk(0, 8'h00, 0, 0, 0, 8'h03, 1, 0, 0);
    tbl[5]  = mk(0, 8'h00, 0, 0, 0, 8'h02, 1, 0, 0);
    tbl[6]  = mk(0, 8'h00, 0, 0, 0, 8'h02, 1, 0, 0);
    tbl[7]  = mk(0, 8'h00, 0, 0, 0, 8'h02, 1, 0, 0);
    tbl[8]  = mk(0, 8'h00, 0, 0, 0, 8'h02, 1, 0, 0);
    tbl[9]  = mk(0, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0);
    tbl[10] = mk(0, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0);
    tbl[11] = mk(0, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0);
    tbl[12] = mk(0, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0);
    tbl[13] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 1);
    tbl[14] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
    tbl[15] = mk(1, 8'hA7, 1, 1, 0, 8'h97, 0, 0, 0);
    tbl[16] = mk(0, 8'h00, 1, 0, 0, 8'h97, 1, 0, 0);
    tbl[17] = mk(0, 8'h00, 0, 1, 0, 8'h97, 0, 0, 0);
    tbl[18] = mk(0, 8'h00, 1, 0, 0, 8'h97, 1, 0, 0);
    tbl[19] = mk(0, 8'h00, 0, 0, 0, 8'h97, 1, 0, 0);
    tbl[20] = mk(0, 8'h00, 0, 0, 0, 8'h97, 1, 0, 0);
    tbl[21] = mk(0, 8'h00, 0, 0, 0, 8'h97, 1, 0, 0);
    tbl[22] = mk(0, 8'h00, 0, 0, 0, 8'h96, 1, 0, 0);
    tbl[23] = mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[24] = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1);
    tbl[25] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
    tbl[26] = mk(1, 8'h01, 0, 0, 1, 8'h01, 0, 0, 0);
    tbl[27] = mk(0, 8'h00, 1, 0, 1, 8'h01, 1, 0, 0);
    tbl[28] = mk(0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0);
    tbl[29] = mk(0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0);
    tbl[30] = mk(0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0);
    tbl[31] = mk(0, 8'h00, 0, 0, 1, 8'h00, 1, 0, 1);
    tbl[32] = mk(0, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0);
    tbl[33] = mk(0, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0);
    tbl[34] = mk(0, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0);
    tbl[35] = mk(0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0);

    // Reset and table vectors on the 2-digit instance
    rst = 1'b1;
    cyc();
    chk("rst_dig2", 32'(dg2), 32'h30);
    chk("rst_seg2", 32'(sg2), 32'b0000110100000011);
    chk("rst_run2", 32'(run2), 32'd0);
    chk("rst_done2", 32'(dn2), 32'd0);
    chk("rst_exp2", 32'(ex2), 32'd0);
    chk("rst_dig3", 32'(dg3), 32'h030);
    for (int i = 0; i < 36; i++) begin
      ld2 = tbl[i].ld; lv2 = tbl[i].lv; st2 = tbl[i].st; ps2 = tbl[i].ps; ar2 = tbl[i].ar;
      cyc();
      chk($sformatf("vec%0d_dig", i),  32'(dg2),  32'(tbl[i].dig));
      chk($sformatf("vec%0d_run", i),  32'(run2), 32'(tbl[i].run));
      chk($sformatf("vec%0d_done", i), 32'(dn2),  32'(tbl[i].dn));
      chk($sformatf("vec%0d_exp", i),  32'(ex2),  32'(tbl[i].ex));
    end
    ar2 = 1'b0;

    // Count down from reset value, one step every DIV clocks
    rst = 1'b1;
    cyc();
    st2 = 1'b1;
    cyc();
    repeat (3) begin
      cyc();
      chk("first_hold", 32'(dg2), 32'h30);
    end
    cyc();
    chk("first_step", 32'(dg2), 32'h29);
    repeat (4) cyc();
    chk("second_step", 32'(dg2), 32'h28);

    // Pause mid-period resumes with the remaining prescaler cycles
    repeat (12) cyc();
    chk("reach_25", 32'(dg2), 32'h25);
    repeat (2) cyc();
    ps2 = 1'b1;
    cyc();
    repeat (20) begin
      cyc();
      chk("pause_hold", 32'(dg2), 32'h25);
    end
    st2 = 1'b1;
    cyc();
    chk("resume_run", 32'(run2), 32'd1);
    cyc();
    chk("resume_wait", 32'(dg2), 32'h25);
    cyc();
    chk("resume_step", 32'(dg2), 32'h24);

    // One-shot expiry and hold in DONE
    ld2 = 1'b1; lv2 = 8'h03; ar2 = 1'b0;
    cyc();
    st2 = 1'b1;
    cyc();
    ne = 0;
    repeat (12) begin
      cyc();
      ne += int'(ex2);
    end
    chk("oneshot_exp_count", 32'(ne), 32'd1);
    chk("oneshot_done", 32'(dn2), 32'd1);
    chk("oneshot_run", 32'(run2), 32'd0);
    repeat (50) cyc();
    chk("done_hold_dig", 32'(dg2), 32'h00);
    chk("done_hold_done", 32'(dn2), 32'd1);

    // Auto-reload: one expire per four-tick period, never leaves RUN
    ld2 = 1'b1; lv2 = 8'h03; ar2 = 1'b1;
    cyc();
    st2 = 1'b1;
    cyc();
    ne = 0;
    run_all = 1'b1;
    repeat (40) begin
      cyc();
      ne += int'(ex2);
      if (!run2) run_all = 1'b0;
    end
    chk("auto_exp_count", 32'(ne), 32'd2);
    chk("auto_running", 32'(run_all), 32'd1);
    chk("auto_dig", 32'(dg2), 32'h01);
    ar2 = 1'b0;

    // Three-digit borrow chain, zero start, reset mid-run
    ld3 = 1'b1; lv3 = 12'h100;
    cyc();
    st3 = 1'b1;
    cyc();
    repeat (4) cyc();
    chk("d3_borrow", 32'(dg3), 32'h099);
    ld3 = 1'b1; lv3 = 12'h000;
    cyc();
    st3 = 1'b1;
    cyc();
    chk("d3_zero_done", 32'(dn3), 32'd1);
    chk("d3_zero_exp", 32'(ex3), 32'd1);
    cyc();
    chk("d3_zero_exp_once", 32'(ex3), 32'd0);
    ld3 = 1'b1; lv3 = 12'h005;
    cyc();
    st3 = 1'b1;
    cyc();
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    chk("d3_rst_dig", 32'(dg3), 32'h030);
    chk("d3_rst_run", 32'(run3), 32'd0);
    ne = 0;
    repeat (10) begin
      cyc();
      ne += int'(ex3);
    end
    chk("d3_rst_no_exp", 32'(ne), 32'd0);

    // Random stimulus against the model
    rst = 1'b1;
    cyc();
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) begin
        ld2 = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          lv2 = 8'($urandom);
        end else begin
          tmp = to_bcd(int'($urandom_range(0, 12)));
          lv2 = tmp[7:0];
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        ld3 = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          lv3 = 12'($urandom);
        end else begin
          lv3 = to_bcd(int'($urandom_range(0, 12)));
        end
      end
      st2 = ($urandom_range(0, 9) == 0);
      st3 = ($urandom_range(0, 9) == 0);
      ps2 = ($urandom_range(0, 24) == 0);
      ps3 = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 199) == 0) ar2 = ~ar2;
      if ($urandom_range(0, 199) == 0) ar3 = ~ar3;
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD countdown timer with 7-segment drive; generalises the fixed 2-digit 30 s countdown.
- Internal tick prescaler, so the whole block runs on the system clock.
- Adds a runtime load value, start/pause control, a one-shot or auto-reload mode, and a done/expire status.
- Sits between the board button debouncers and the display scanner: per-digit segment codes out, status to the top-level FSM.

Parameters:
- NUM_DIGITS, 2, number of BCD digits; count width is 4*NUM_DIGITS.
- TICK_DIV, 100000000, clk cycles per count step (1 Hz at 100 MHz); must be >= 2.
- RESET_VAL, 'h30, packed BCD count value after reset; every nibble must be <= 9.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse: capture load_val into the count, go IDLE.
- load_val  in  4*NUM_DIGITS  packed BCD load value, digit 0 in [3:0].
- start  in  1  one-cycle pulse: begin or resume counting.
- pause  in  1  one-cycle pulse: freeze counting.
- auto_reload  in  1  level input. 1 = reload the last loaded value at expiry; 0 = one-shot.
- digits  out  4*NUM_DIGITS  current packed BCD count.
- seg  out  8*NUM_DIGITS  active-low segment code per digit, bits {a,b,c,d,e,f,g,dp}, digit 0 in [7:0].
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- expire  out  1  one-cycle pulse when the count reaches 0.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, count=RESET_VAL, reload_reg=RESET_VAL, prescaler=0, expire=0, running=0, done=0.
- FSM states: IDLE, RUN, PAUSE, DONE.
- Input priority when pulses coincide: load > start > pause.
- load (any state):
  - count and reload_reg take load_val.
  - Any nibble >9 is clamped to 9 independently.
  - prescaler=0, state=IDLE.
- start:
  - From IDLE or PAUSE: go to RUN; count and prescaler are unchanged.
  - From DONE: count=reload_reg, prescaler=0, go to RUN.
  - In RUN: ignored.
  - If the count is 0 when start arrives: go to DONE instead of RUN and pulse expire next cycle. This holds in both modes.
- pause: RUN -> PAUSE, prescaler holds its value; ignored in every other state.
- Prescaler:
  - Increments only in RUN.
  - When it equals TICK_DIV-1: wraps to 0 and asserts an internal tick for that cycle.
- On tick in RUN:
  - count > 1: BCD decrement with a borrow chain (a digit at 0 borrows and becomes 9; e.g. 'h10 -> 'h09, 'h100 -> 'h099).
  - count == 1: count becomes 0 and expire pulses on the same edge, visible for exactly one cycle.
    - auto_reload=0: state becomes DONE.
    - auto_reload=1: state stays RUN.
  - count == 0 (auto_reload only): count=reload_reg, no expire. The display therefore shows 0 for one full tick period.
- auto_reload is sampled at the tick where the count reaches 0. Changing it mid-run has no other effect.
- DONE holds count=0 until load or start.
- Registered outputs update on the clk edge; digits and seg follow the count with 0 cycle latency (combinational decode of the count register).
- Segment codes (active-low):
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
  - 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001
  - Any other nibble (unreachable) = 01110001 ("F").
- rst asserted mid-run aborts immediately. No expire pulse is produced.

Test Plan:
- NUM_DIGITS=2, TICK_DIV=4, reset, start -> count 'h30 then 'h29 four clocks later, then 'h28 each 4 clocks; seg[15:0] = {00001101,00000011} after reset.
- load_val='h03, load, start, auto_reload=0 -> 'h02, 'h01, 'h00 at ticks; expire high exactly one cycle with the 'h00 edge; done=1, running=0; count holds 'h00 for 50 further cycles.
- Same with auto_reload=1 -> after 'h00, the next tick shows 'h03; expire pulses once per period; running stays 1.
- Running at 'h25, pause for 20 cycles, then start -> count frozen during pause; the next decrement arrives after the remaining prescaler cycles, not after a full 4.
- Same cycle load=1, start=1, pause=1 with load_val='hA7 -> count='h97, state IDLE; a later start counts from 'h97.
- NUM_DIGITS=3, load 'h100, run -> 'h099 after one tick. Then load 'h000 and start -> done=1 and one expire pulse. Then rst mid-RUN -> count='h30-equivalent RESET_VAL, IDLE, no expire.
